// File: rtl/ofdm_pilot_inserter.sv
// rtl/ofdm_pilot_inserter.sv - two-bank ping-pong OFDM symbol builder with DC/guard nulls and scrambled BPSK pilots
module ofdm_pilot_inserter #(
  parameter int DATA_W    = 16,
  parameter int NFFT      = 64,
  parameter int PILOT_AMP = 11585
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] D1_re,
  input  logic [DATA_W-1:0] D1_im,
  input  logic [DATA_W-1:0] D2_re,
  input  logic [DATA_W-1:0] D2_im,
  output logic              out_valid,
  output logic [DATA_W-1:0] X1_re,
  output logic [DATA_W-1:0] X1_im,
  output logic [DATA_W-1:0] X2_re,
  output logic [DATA_W-1:0] X2_im,
  output logic [5:0]        out_sc_idx,
  output logic              out_sop,
  output logic              out_eop
);

  localparam logic [5:0]        LAST_K  = 6'(NFFT - 1);
  localparam logic [DATA_W-1:0] AMP_POS = PILOT_AMP[DATA_W-1:0];
  localparam logic [DATA_W-1:0] AMP_NEG = ~AMP_POS + 1'b1;

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  state_t            state_q, state_d;
  logic [5:0]        k_q, k_d;
  logic [1:0]        full_q, full_d;
  logic              wb_q, wb_d, rb_q, rb_d;
  logic [5:0]        wr_addr_q, wr_addr_d;
  logic [6:0]        lfsr_q, lfsr_d;
  logic              pol_q, pol_d;
  logic              out_valid_q, out_valid_d, sop_q, sop_d, eop_q, eop_d;
  logic [5:0]        idx_q, idx_d;
  logic [DATA_W-1:0] x1re_q, x1re_d, x1im_q, x1im_d, x2re_q, x2re_d, x2im_q, x2im_d;

  logic [4*DATA_W-1:0] bank_mem [2][48];

  // An emitter in IDLE starts k=0 in the same cycle it sees a full bank, so
  // the first sample is registered one edge after the bank filled.
  logic       accept, fire, last_k, fb, is_null, is_pilot, s1_neg, s2_neg;
  logic [5:0] cur_k, rd_addr;
  logic [4*DATA_W-1:0] rd_word;

  assign in_ready = ~full_q[wb_q];
  assign accept   = in_valid & in_ready;
  assign fire     = (state_q == S_EMIT) | full_q[rb_q];
  assign cur_k    = (state_q == S_EMIT) ? k_q : 6'd0;
  assign last_k   = (cur_k == LAST_K);
  assign fb       = lfsr_q[6] ^ lfsr_q[3];
  assign is_null  = (cur_k == 6'd0) | ((cur_k >= 6'd27) & (cur_k <= 6'd37));
  assign is_pilot = (cur_k == 6'd7) | (cur_k == 6'd21) | (cur_k == 6'd43) | (cur_k == 6'd57);
  assign rd_word  = bank_mem[rb_q][rd_addr];

  // State and bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      k_q         <= 6'd0;
      full_q      <= 2'b00;
      wb_q        <= 1'b0;
      rb_q        <= 1'b0;
      wr_addr_q   <= 6'd0;
      lfsr_q      <= 7'h7F;
      pol_q       <= 1'b0;
      out_valid_q <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      idx_q       <= 6'd0;
      x1re_q      <= '0;
      x1im_q      <= '0;
      x2re_q      <= '0;
      x2im_q      <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      full_q      <= full_d;
      wb_q        <= wb_d;
      rb_q        <= rb_d;
      wr_addr_q   <= wr_addr_d;
      lfsr_q      <= lfsr_d;
      pol_q       <= pol_d;
      out_valid_q <= out_valid_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      idx_q       <= idx_d;
      x1re_q      <= x1re_d;
      x1im_q      <= x1im_d;
      x2re_q      <= x2re_d;
      x2im_q      <= x2im_d;
    end
  end

  // Symbol store: both streams of one data subcarrier per word, no reset needed
  always_ff @(posedge clk) begin
    if (accept) bank_mem[wb_q][wr_addr_q] <= {D1_re, D1_im, D2_re, D2_im};
  end

  // Next-state: run k through a symbol, chain straight into the other bank if it is ready
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    if (fire) begin
      if (last_k) begin
        k_d     = 6'd0;
        state_d = full_q[~rb_q] ? S_EMIT : S_IDLE;
      end else begin
        k_d     = cur_k + 6'd1;
        state_d = S_EMIT;
      end
    end
  end

  // Bank ownership, write pointer and pilot polarity scrambler
  always_comb begin
    full_d    = full_q;
    wb_d      = wb_q;
    rb_d      = rb_q;
    wr_addr_d = wr_addr_q;
    lfsr_d    = lfsr_q;
    pol_d     = pol_q;
    if (accept) begin
      if (wr_addr_q == 6'd47) begin
        full_d[wb_q] = 1'b1;
        wb_d         = ~wb_q;
        wr_addr_d    = 6'd0;
      end else begin
        wr_addr_d = wr_addr_q + 6'd1;
      end
    end
    if (fire && (cur_k == 6'd0)) begin
      lfsr_d = {lfsr_q[5:0], fb};
      pol_d  = fb;
    end
    // The writer can never be on rb here, so this release cannot collide with a fill above
    if (fire && last_k) begin
      full_d[rb_q] = 1'b0;
      rb_d         = ~rb_q;
    end
  end

  // Data-subcarrier address: k minus the nulls and pilots that precede it
  always_comb begin
    rd_addr = 6'd0;
    if (!is_null) begin
      if (cur_k <= 6'd6)       rd_addr = cur_k - 6'd1;
      else if (cur_k <= 6'd20) rd_addr = cur_k - 6'd2;
      else if (cur_k <= 6'd26) rd_addr = cur_k - 6'd3;
      else if (cur_k <= 6'd42) rd_addr = cur_k - 6'd14;
      else if (cur_k <= 6'd56) rd_addr = cur_k - 6'd15;
      else                     rd_addr = cur_k - 6'd16;
    end
  end

  // Output sample: null, pilot or stored data, zero whenever not emitting
  always_comb begin
    s1_neg      = pol_q ^ (cur_k == 6'd21);
    s2_neg      = pol_q ^ (cur_k == 6'd43);
    out_valid_d = fire;
    sop_d       = fire & (cur_k == 6'd0);
    eop_d       = fire & last_k;
    idx_d       = fire ? cur_k : 6'd0;
    x1re_d      = '0;
    x1im_d      = '0;
    x2re_d      = '0;
    x2im_d      = '0;
    if (fire && is_pilot) begin
      x1re_d = s1_neg ? AMP_NEG : AMP_POS;
      x2re_d = s2_neg ? AMP_NEG : AMP_POS;
    end else if (fire && !is_null) begin
      {x1re_d, x1im_d, x2re_d, x2im_d} = rd_word;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sop    = sop_q;
  assign out_eop    = eop_q;
  assign out_sc_idx = idx_q;
  assign X1_re      = x1re_q;
  assign X1_im      = x1im_q;
  assign X2_re      = x2re_q;
  assign X2_im      = x2im_q;

endmodule
